// File: rtl/dm_bank.sv
`default_nettype none
// ============================================================================
// Module : dm_bank
// Per-PE data-memory bank with a bit-masked PE port and a lower-priority
// valid/ready host port for preload and drain.
// Rev    : 1.0  initial release
// ============================================================================
module dm_bank #(
  parameter int DATA_WIDTH   = 32,
  parameter int DM_DEPTH     = 512,
  parameter int ADDR_BITS    = $clog2(DM_DEPTH),
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  // PE (load/store) port, active-low controls
  input  logic                  rd_en_dm,
  input  logic                  wr_en_dm,
  input  logic [ADDR_BITS-1:0]  addr_dm,
  input  logic [DATA_WIDTH-1:0] data_in_dm,
  input  logic [DATA_WIDTH-1:0] bit_en,
  output logic [DATA_WIDTH-1:0] data_out_dm,
  // host port
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_req_we,
  input  logic [ADDR_BITS-1:0]  host_req_addr,
  input  logic [DATA_WIDTH-1:0] host_req_wdata,
  output logic                  host_rsp_valid,
  input  logic                  host_rsp_ready,
  output logic [DATA_WIDTH-1:0] host_rsp_data,
  output logic                  host_starve
);

  localparam int                c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  logic [DATA_WIDTH-1:0] r_mem [DM_DEPTH];

  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [c_CNT_W-1:0]    r_starve_cnt;
  logic                  r_starve;

  logic                  w_pe_sel;
  logic                  w_pe_wr;
  logic                  w_pe_rd;
  logic                  w_pe_in_rng;
  logic                  w_host_in_rng;
  logic                  w_host_fire;
  logic                  w_host_wr;
  logic                  w_host_rd;
  logic [DATA_WIDTH-1:0] w_pe_word;
  logic [DATA_WIDTH-1:0] w_host_word;

  assign w_pe_sel = ~rd_en_dm;
  assign w_pe_wr  = w_pe_sel & ~wr_en_dm;
  assign w_pe_rd  = w_pe_sel &  wr_en_dm;

  // A stalled response blocks new host requests so no read result is lost.
  assign host_req_ready = ~w_pe_sel & ~(r_rsp_valid & ~host_rsp_ready);
  assign w_host_fire    = host_req_valid & host_req_ready;
  assign w_host_wr      = w_host_fire &  host_req_we;
  assign w_host_rd      = w_host_fire & ~host_req_we;

  generate
    if (DM_DEPTH < (1 << ADDR_BITS)) begin : g_range_chk
      localparam logic [ADDR_BITS:0] c_DEPTH = (ADDR_BITS + 1)'(DM_DEPTH);
      assign w_pe_in_rng   = ({1'b0, addr_dm}       < c_DEPTH);
      assign w_host_in_rng = ({1'b0, host_req_addr} < c_DEPTH);
    end else begin : g_full_range
      assign w_pe_in_rng   = 1'b1;
      assign w_host_in_rng = 1'b1;
    end
  endgenerate

  assign w_pe_word   = w_pe_in_rng   ? r_mem[addr_dm]       : '0;
  assign w_host_word = w_host_in_rng ? r_mem[host_req_addr] : '0;

  // Storage array: no reset, writes suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_pe_wr && w_pe_in_rng) begin
        r_mem[addr_dm] <= (w_pe_word & ~bit_en) | (data_in_dm & bit_en);
      end else if (w_host_wr && w_host_in_rng) begin
        r_mem[host_req_addr] <= host_req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else begin
      if (w_pe_rd) begin
        r_data_out <= w_pe_word;
      end

      // A read firing while the old response is accepted reloads in place.
      if (w_host_rd) begin
        r_rsp_data  <= w_host_word;
        r_rsp_valid <= 1'b1;
      end else if (host_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      if (w_host_fire || !host_req_valid) begin
        r_starve_cnt <= '0;
      end else if (w_pe_sel && (r_starve_cnt != c_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      if (host_req_valid && w_pe_sel && (r_starve_cnt == (c_LIMIT - 1'b1))) begin
        r_starve <= 1'b1;
      end
    end
  end

  assign data_out_dm    = r_data_out;
  assign host_rsp_valid = r_rsp_valid;
  assign host_rsp_data  = r_rsp_data;
  assign host_starve    = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_dm_bank.sv
`default_nettype none
// Testbench for dm_bank: directed scenarios plus randomized PE/host traffic
// checked against a behavioural model of the bank.
module tb_dm_bank;
  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int LIMIT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en_dm, wr_en_dm;
  logic [AW-1:0] addr_dm;
  logic [DW-1:0] data_in_dm, bit_en, data_out_dm;
  logic          host_req_valid, host_req_ready, host_req_we;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_wdata;
  logic          host_rsp_valid, host_rsp_ready;
  logic [DW-1:0] host_rsp_data;
  logic          host_starve;

  dm_bank #(
    .DATA_WIDTH(DW), .DM_DEPTH(DEPTH), .ADDR_BITS(AW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_en_dm(rd_en_dm), .wr_en_dm(wr_en_dm), .addr_dm(addr_dm),
    .data_in_dm(data_in_dm), .bit_en(bit_en), .data_out_dm(data_out_dm),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_we(host_req_we), .host_req_addr(host_req_addr),
    .host_req_wdata(host_req_wdata), .host_rsp_valid(host_rsp_valid),
    .host_rsp_ready(host_rsp_ready), .host_rsp_data(host_rsp_data),
    .host_starve(host_starve)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_dout, m_rsp_data;
  logic          m_rsp_valid, m_starve;
  int            m_run;
  int            n_checks = 0;
  int            n_pass   = 0;

  function automatic logic exp_ready();
    return rd_en_dm && !(m_rsp_valid && !host_rsp_ready);
  endfunction

  task automatic idle();
    rd_en_dm = 1'b1; wr_en_dm = 1'b1; addr_dm = '0; data_in_dm = '0; bit_en = '0;
    host_req_valid = 1'b0; host_req_we = 1'b0; host_req_addr = '0;
    host_req_wdata = '0; host_rsp_ready = 1'b1;
  endtask

  // Advance the model by one cycle from the current inputs, then the clock.
  task automatic cycle();
    logic fire;
    fire = host_req_valid && exp_ready();
    if (reset) begin
      m_dout = '0; m_rsp_valid = 1'b0; m_rsp_data = '0; m_run = 0; m_starve = 1'b0;
    end else begin
      if (!rd_en_dm && wr_en_dm) m_dout = m_mem[addr_dm];
      if (fire && !host_req_we) begin
        m_rsp_data = m_mem[host_req_addr]; m_rsp_valid = 1'b1;
      end else if (host_rsp_ready) begin
        m_rsp_valid = 1'b0;
      end
      if (!rd_en_dm && !wr_en_dm) begin
        for (int b = 0; b < DW; b++)
          if (bit_en[b]) m_mem[addr_dm][b] = data_in_dm[b];
      end
      if (fire && host_req_we) m_mem[host_req_addr] = host_req_wdata;
      if (fire || !host_req_valid) m_run = 0;
      else if (!rd_en_dm) m_run = m_run + 1;
      if (m_run >= LIMIT) m_starve = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (data_out_dm !== '0) $display("FAIL reset_dout: got %h want 0", data_out_dm); else n_pass++;
    n_checks++; if (host_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", host_rsp_valid); else n_pass++;
    n_checks++; if (host_rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 0", host_rsp_data); else n_pass++;
    n_checks++; if (host_starve !== 1'b0) $display("FAIL reset_starve: got %b want 0", host_starve); else n_pass++;
    n_checks++; if (host_req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", host_req_ready); else n_pass++;
  endtask

  task automatic test_pe_write_read();
    idle(); rd_en_dm = 1'b0; wr_en_dm = 1'b0; addr_dm = 9'd5;
    data_in_dm = 32'hDEADBEEF; bit_en = '1;
    cycle();
    n_checks++; if (data_out_dm !== '0) $display("FAIL write_keeps_dout: got %h want 0", data_out_dm); else n_pass++;
    wr_en_dm = 1'b1;
    cycle();
    n_checks++; if (data_out_dm !== 32'hDEADBEEF) $display("FAIL pe_read5: got %h want deadbeef", data_out_dm); else n_pass++;
  endtask

  task automatic test_masked();
    idle(); rd_en_dm = 1'b0; wr_en_dm = 1'b0; addr_dm = 9'd7;
    data_in_dm = 32'hFFFFFFFF; bit_en = '1;                cycle();
    data_in_dm = 32'h000000AB; bit_en = 32'h000000FF;      cycle();
    data_in_dm = 32'h0000CD00; bit_en = 32'h0000FF00;      cycle();
    wr_en_dm = 1'b1;                                       cycle();
    n_checks++; if (data_out_dm !== 32'hFFFFCDAB) $display("FAIL masked_write: got %h want ffffcdab", data_out_dm); else n_pass++;
    rd_en_dm = 1'b1; wr_en_dm = 1'b0; data_in_dm = '0; bit_en = '1; cycle();
    rd_en_dm = 1'b0; wr_en_dm = 1'b1;                      cycle();
    n_checks++; if (data_out_dm !== 32'hFFFFCDAB) $display("FAIL idle_no_write: got %h want ffffcdab", data_out_dm); else n_pass++;
  endtask

  task automatic test_host_write();
    idle(); host_req_valid = 1'b1; host_req_we = 1'b1;
    host_req_addr = 9'd3; host_req_wdata = 32'h12345678;
    #1;
    n_checks++; if (host_req_ready !== 1'b1) $display("FAIL host_wr_ready: got %b want 1", host_req_ready); else n_pass++;
    cycle();
    idle(); rd_en_dm = 1'b0; addr_dm = 9'd3;
    #1;
    n_checks++; if (host_req_ready !== 1'b0) $display("FAIL pe_blocks_host: got %b want 0", host_req_ready); else n_pass++;
    cycle();
    n_checks++; if (data_out_dm !== 32'h12345678) $display("FAIL host_wr_readback: got %h want 12345678", data_out_dm); else n_pass++;
  endtask

  task automatic preload();
    for (int a = 0; a < 32; a++) begin
      idle(); host_req_valid = 1'b1; host_req_we = 1'b1;
      host_req_addr = AW'(a); host_req_wdata = $urandom;
      cycle();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] held;
    idle(); host_req_valid = 1'b1; host_req_we = 1'b0; host_rsp_ready = 1'b1;
    for (int a = 0; a < 3; a++) begin
      host_req_addr = AW'(a);
      #1;
      n_checks++; if (host_req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", a, host_req_ready); else n_pass++;
      cycle();
      n_checks++; if (host_rsp_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", a, host_rsp_valid); else n_pass++;
      n_checks++; if (host_rsp_data !== m_mem[a]) $display("FAIL b2b_data[%0d]: got %h want %h", a, host_rsp_data, m_mem[a]); else n_pass++;
    end
    held = m_mem[2];
    host_req_valid = 1'b0; host_rsp_ready = 1'b0;
    #1;
    n_checks++; if (host_req_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", host_req_ready); else n_pass++;
    cycle();
    host_req_valid = 1'b1; host_req_addr = 9'd9;
    cycle();
    n_checks++; if (host_rsp_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b want 1", host_rsp_valid); else n_pass++;
    n_checks++; if (host_rsp_data !== held) $display("FAIL bp_data_hold: got %h want %h", host_rsp_data, held); else n_pass++;
    host_req_valid = 1'b0; host_rsp_ready = 1'b1;
    cycle();
    n_checks++; if (host_rsp_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", host_rsp_valid); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rd_en_dm       = 1'($urandom_range(0, 1));
      wr_en_dm       = 1'($urandom_range(0, 1));
      addr_dm        = AW'($urandom_range(0, 31));
      data_in_dm     = $urandom;
      bit_en         = $urandom;
      host_req_valid = 1'($urandom_range(0, 1));
      host_req_we    = 1'($urandom_range(0, 1));
      host_req_addr  = AW'($urandom_range(0, 31));
      host_req_wdata = $urandom;
      host_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++; if (host_req_ready !== exp_ready()) $display("FAIL rnd_ready[%0d]: got %b want %b", i, host_req_ready, exp_ready()); else n_pass++;
      cycle();
      n_checks++; if (data_out_dm !== m_dout) $display("FAIL rnd_dout[%0d]: got %h want %h", i, data_out_dm, m_dout); else n_pass++;
      n_checks++; if (host_rsp_valid !== m_rsp_valid) $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", i, host_rsp_valid, m_rsp_valid); else n_pass++;
      n_checks++; if (host_rsp_data !== m_rsp_data) $display("FAIL rnd_rsp_data[%0d]: got %h want %h", i, host_rsp_data, m_rsp_data); else n_pass++;
      n_checks++; if (host_starve !== m_starve) $display("FAIL rnd_starve[%0d]: got %b want %b", i, host_starve, m_starve); else n_pass++;
    end
    idle();
    cycle();
  endtask

  task automatic test_starve();
    idle(); reset = 1'b1; cycle(); reset = 1'b0;
    rd_en_dm = 1'b0; wr_en_dm = 1'b1; addr_dm = 9'd0;
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 9'd4;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      n_checks++; if (host_starve !== (i >= LIMIT)) $display("FAIL starve_cycle[%0d]: got %b want %b", i, host_starve, (i >= LIMIT)); else n_pass++;
    end
    rd_en_dm = 1'b1;
    #1;
    n_checks++; if (host_req_ready !== 1'b1) $display("FAIL starve_release_ready: got %b want 1", host_req_ready); else n_pass++;
    cycle();
    n_checks++; if (host_rsp_data !== m_mem[4]) $display("FAIL starve_fire_data: got %h want %h", host_rsp_data, m_mem[4]); else n_pass++;
    host_req_valid = 1'b0;
    cycle();
    n_checks++; if (host_starve !== 1'b1) $display("FAIL starve_sticky: got %b want 1", host_starve); else n_pass++;
  endtask

  task automatic test_reset_midtxn();
    logic [DW-1:0] old;
    idle(); host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 9'd6;
    host_rsp_ready = 1'b0;
    cycle();
    n_checks++; if (host_rsp_valid !== 1'b1) $display("FAIL mid_rsp_pending: got %b want 1", host_rsp_valid); else n_pass++;
    old = m_mem[10];
    idle(); host_rsp_ready = 1'b0; reset = 1'b1;
    rd_en_dm = 1'b0; wr_en_dm = 1'b0; addr_dm = 9'd10; data_in_dm = ~old; bit_en = '1;
    cycle();
    reset = 1'b0;
    n_checks++; if (host_rsp_valid !== 1'b0) $display("FAIL mid_rsp_dropped: got %b want 0", host_rsp_valid); else n_pass++;
    n_checks++; if (data_out_dm !== '0) $display("FAIL mid_dout_cleared: got %h want 0", data_out_dm); else n_pass++;
    idle(); rd_en_dm = 1'b0; addr_dm = 9'd10;
    cycle();
    n_checks++; if (data_out_dm !== old) $display("FAIL mid_write_suppressed: got %h want %h", data_out_dm, old); else n_pass++;
  endtask

  initial begin
    idle(); reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_pe_write_read();
    test_masked();
    test_host_write();
    preload();
    test_back_to_back();
    test_random();
    test_starve();
    test_reset_midtxn();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
